// File: rtl/ascon_seq_ctrl.sv
// Ascon job sequencer: accepts a job command, starts the engine, streams AD/PT words in,
// drains CT words out and hands back the tag. Optional watchdog under ASCON_SEQ_TIMEOUT_EN.
module ascon_seq_ctrl #(
  parameter int unsigned DATA_AW   = 7,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [DATA_AW-1:0] cmd_ad_size_i,
  input  logic [DATA_AW-1:0] cmd_pt_size_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [63:0]        in_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [63:0]        out_data_o,
  output logic               tag_valid_o,
  input  logic               tag_ready_i,
  output logic [127:0]       tag_o,
  output logic               start_o,
  input  logic               ready_i,
  input  logic               tag_valid_i,
  input  logic [127:0]       tag_i,
  output logic [DATA_AW-1:0] ad_size_o,
  output logic [DATA_AW-1:0] pt_size_o,
  output logic               ad_push_o,
  output logic [63:0]        ad_o,
  input  logic               ad_full_i,
  output logic               pt_push_o,
  output logic [63:0]        pt_o,
  input  logic               pt_full_i,
  output logic               ct_pop_o,
  input  logic [63:0]        ct_i,
  input  logic               ct_empty_i,
  output logic               busy_o,
  output logic               err_o
);

  typedef enum logic [1:0] {IDLE, START, FEED, TAG} state_t;

  state_t             state, state_nxt;
  logic [DATA_AW-1:0] ad_cnt, pt_cnt, ct_cnt;
  logic [127:0]       tag_q;
  logic               tag_seen;
  logic               feed, ad_phase, pt_phase, cmd_acc, timeout;

  always_comb begin
    feed     = (state == FEED);
    ad_phase = (ad_cnt != '0);
    pt_phase = !ad_phase && (pt_cnt != '0);
    cmd_acc  = (state == IDLE) && cmd_valid_i;
  end

  assign cmd_ready_o = (state == IDLE);
  assign start_o     = (state == START) && ready_i;
  assign busy_o      = (state != IDLE);
  assign in_ready_o  = feed && ((ad_phase && !ad_full_i) || (pt_phase && !pt_full_i));
  assign ad_push_o   = feed && ad_phase && in_valid_i && !ad_full_i;
  assign pt_push_o   = feed && pt_phase && in_valid_i && !pt_full_i;
  assign ad_o        = in_data_i;
  assign pt_o        = in_data_i;
  assign out_valid_o = feed && !ct_empty_i && (ct_cnt != '0);
  assign ct_pop_o    = out_valid_o && out_ready_i;
  assign out_data_o  = ct_i;
  assign tag_valid_o = (state == TAG);
  assign tag_o       = tag_q;

`ifdef ASCON_SEQ_TIMEOUT_EN
  // Fires on the stalled cycle that would bring the counter to all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = ~(TIMEOUT_W'(1));
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 err_q;
  logic                 wd_active, wd_stalled;

  always_comb begin
    wd_active  = (state == START) || (state == FEED);
    wd_stalled = wd_active && !(ad_push_o || pt_push_o || ct_pop_o || tag_valid_i);
    timeout    = wd_stalled && (wd_cnt == WD_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (wd_stalled && !timeout) wd_cnt <= wd_cnt + TIMEOUT_W'(1);
      else                        wd_cnt <= '0;
      if (cmd_acc)      err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cmd_valid_i) state_nxt = START;
      START: if (ready_i) state_nxt = FEED;
      FEED:  if (ad_cnt == '0 && pt_cnt == '0 && ct_cnt == '0 && (tag_seen || tag_valid_i))
               state_nxt = TAG;
      TAG:   if (tag_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ad_size_o <= '0;
      pt_size_o <= '0;
      ad_cnt    <= '0;
      pt_cnt    <= '0;
      ct_cnt    <= '0;
      tag_q     <= '0;
      tag_seen  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_acc) begin
        ad_size_o <= cmd_ad_size_i;
        pt_size_o <= cmd_pt_size_i;
        ad_cnt    <= cmd_ad_size_i;
        pt_cnt    <= cmd_pt_size_i;
        ct_cnt    <= cmd_pt_size_i;
      end else begin
        if (ad_push_o) ad_cnt <= ad_cnt - DATA_AW'(1);
        if (pt_push_o) pt_cnt <= pt_cnt - DATA_AW'(1);
        if (ct_pop_o)  ct_cnt <= ct_cnt - DATA_AW'(1);
      end
      if (state != IDLE && tag_valid_i) begin
        tag_q    <= tag_i;
        tag_seen <= 1'b1;
      end
      if ((state == TAG && tag_ready_i) || timeout) tag_seen <= 1'b0;
    end
  end

endmodule

// File: doc/ascon_seq_ctrl.md
ASCON_SEQ_CTRL -- requirements
Module: ascon_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_AW, default 7: width of AD/PT block counts.
REQ-002 SHALL have parameter TIMEOUT_W, default 16: watchdog counter width.
REQ-003 SHALL have port clk  in  1: single clock. All logic is rising-edge.
REQ-004 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-005 SHALL have port cmd_valid_i  in  1 and port cmd_ready_o  out  1: job command handshake.
REQ-006 SHALL have ports cmd_ad_size_i and cmd_pt_size_i  in  DATA_AW each: 64-bit AD and PT block counts.
REQ-007 SHALL have ports in_valid_i  in  1, in_ready_o  out  1 and in_data_i  in  64: AD words, then PT words.
REQ-008 SHALL have ports out_valid_o  out  1, out_ready_i  in  1 and out_data_o  out  64: CT word stream.
REQ-009 SHALL have ports tag_valid_o  out  1, tag_ready_i  in  1 and tag_o  out  128: tag handshake.
REQ-010 SHALL have ports start_o  out  1, ready_i  in  1, tag_valid_i  in  1 and tag_i  in  128: engine control.
REQ-011 SHALL have ports ad_size_o and pt_size_o  out  DATA_AW: latched command sizes.
REQ-012 SHALL have ports ad_push_o  out  1, ad_o  out  64 and ad_full_i  in  1: AD FIFO.
REQ-013 SHALL have ports pt_push_o  out  1, pt_o  out  64 and pt_full_i  in  1: PT FIFO.
REQ-014 SHALL have ports ct_pop_o  out  1, ct_i  in  64 and ct_empty_i  in  1: CT FIFO.
REQ-015 SHALL have ports busy_o  out  1 and err_o  out  1: status.

Function
REQ-016 SHALL implement FSM states IDLE, START, FEED, TAG.
REQ-017 In IDLE, cmd_ready_o SHALL equal 1; on cmd_valid_i, sizes latch into ad_size_o/pt_size_o, remaining-word counters load, and the FSM goes to START.
REQ-018 In START, start_o SHALL pulse for exactly one cycle, in the first cycle ready_i=1; the FSM then goes to FEED.
REQ-019 In FEED, while the AD count is nonzero, in_ready_o=!ad_full_i, ad_push_o=in_valid_i&&in_ready_o, ad_o=in_data_i, and the AD count decrements per push.
REQ-020 In FEED, once the AD count is zero, in_ready_o=!pt_full_i, pt_push_o=in_valid_i&&in_ready_o, pt_o=in_data_i, and the PT count decrements per push.
REQ-021 Pushes SHALL be combinational from the handshake, so one word moves per cycle with zero added latency.
REQ-022 In FEED, concurrently with pushing, out_valid_o=!ct_empty_i&&(CT count>0), out_data_o=ct_i, ct_pop_o=out_valid_o&&out_ready_i, and the CT count (loaded with the PT size) decrements per pop.
REQ-023 A tag_valid_i pulse in any non-IDLE state SHALL latch tag_i plus a tag-seen flag.
REQ-024 FEED SHALL go to TAG when AD, PT and CT counts are all zero and the tag-seen flag is set, including when tag_valid_i arrives in that same cycle.
REQ-025 In TAG, tag_valid_o=1 and tag_o holds the latched tag until tag_ready_i, then the FSM returns to IDLE and the flag clears.
REQ-026 Zero-size AD and/or PT SHALL be legal, with no push/pop issued for that section; 0/0 goes straight to waiting for the tag.
REQ-027 in_ready_o=0 SHALL hold in IDLE, START and TAG, and after all PT words are pushed.
REQ-028 busy_o SHALL be 1 in every state except IDLE.
REQ-029 out_ready_i=0 SHALL stall CT draining only; pushes continue.

Reset
REQ-030 While rst=1, the FSM SHALL go to IDLE, all counters/flags/tag register clear to 0, start_o, push/pop, out_valid_o, tag_valid_o, busy_o and err_o = 0, and ad_size_o/pt_size_o = 0.
REQ-031 rst asserted mid-job SHALL abandon the job immediately, with no further pushes or pops after assertion.

Configuration
REQ-032 When ASCON_SEQ_TIMEOUT_EN is defined, a TIMEOUT_W-bit watchdog SHALL count cycles in START/FEED without any push, pop or tag_valid_i; at all-ones it sets err_o (sticky until the next accepted command) and forces IDLE.
REQ-033 When ASCON_SEQ_TIMEOUT_EN is undefined, no watchdog logic SHALL exist and err_o SHALL be tied to 0.

Verification
REQ-034 Command ad=2, pt=3, FIFOs never full, out_ready_i=1 -> one start_o pulse, 2 ad_push_o then 3 pt_push_o on consecutive cycles, 3 ct_pop_o, tag_valid_o after tag_valid_i, back to IDLE.
REQ-035 Command ad=0, pt=0 -> no push/pop; tag returned after tag_valid_i; busy_o drops on the tag_ready_i cycle.
REQ-036 ad=1, pt=4 with pt_full_i high for 5 cycles and out_ready_i toggling -> no push during full, no pop while out_ready_i=0, exact counts preserved.
REQ-037 tag_valid_i asserted before the last CT pop -> tag latched; tag_valid_o only after the final pop.
REQ-038 rst pulsed after 1 of 3 PT pushes -> all outputs 0 next cycle, cmd_ready_o=1 after release, a new job completes cleanly.
REQ-039 With ASCON_SEQ_TIMEOUT_EN and TIMEOUT_W=4, hold ad_full_i=1 -> err_o=1 and IDLE after 15 stalled cycles; err_o clears on the next command.
